fp_console_ctrl: RTL and testbench

//  CPU-side master of the front_panel_pins interface. Consumes the panel's run level and its one-cycle

---
 rtl/fp_console_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fp_console_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_console_ctrl.sv
// Front-panel console sequencer: turns panel run level and command pulses into
// PDP-8 core run/step/load controls and a memory-write handshake, and drives the panel display.
module fp_console_ctrl #(
  parameter int DW          = 12,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          loadpc,
  input  logic          loadac,
  input  logic          step,
  input  logic          deposit,
  input  logic [DW-1:0] swreg,
  input  logic [1:0]    dispsel,
  output logic [DW-1:0] dispout,
  output logic          linkout,
  input  logic [DW-1:0] cpu_pc,
  input  logic [DW-1:0] cpu_ac,
  input  logic [DW-1:0] cpu_mb,
  input  logic [DW-1:0] cpu_ir,
  input  logic          cpu_link,
  input  logic          instr_done,
  output logic          cpu_run,
  output logic          step_req,
  input  logic          step_done,
  output logic          pc_ld,
  output logic          ac_ld,
  output logic [DW-1:0] ld_val,
  output logic          mem_wr_req,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_wr_ack,
  output logic          fp_busy,
  output logic          fp_err
);

  localparam int            CW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_HALTING, S_STEP_WAIT, S_DEP_WAIT, S_DEP_INC
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pc_ld_q, pc_ld_d, ac_ld_q, ac_ld_d;
  logic [DW-1:0] ld_val_q, ld_val_d;
  logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] disp_q, disp_d;
  logic          link_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pc_ld_q  <= 1'b0;
      ac_ld_q  <= 1'b0;
      ld_val_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      disp_q   <= '0;
      link_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_ld_q  <= pc_ld_d;
      ac_ld_q  <= ac_ld_d;
      ld_val_q <= ld_val_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      disp_q   <= disp_d;
      link_q   <= cpu_link;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_ld_d  = 1'b0;
    ac_ld_d  = 1'b0;
    ld_val_d = ld_val_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    unique case (dispsel)
      2'b00:   disp_d = cpu_pc;
      2'b01:   disp_d = cpu_ac;
      2'b10:   disp_d = cpu_mb;
      default: disp_d = cpu_ir;
    endcase
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // run level beats any pulse; lower-priority simultaneous pulses are dropped
        if (run) begin
          state_d = S_RUN;
        end else if (loadpc) begin
          pc_ld_d  = 1'b1;
          ld_val_d = swreg;
          err_d    = 1'b0;
        end else if (loadac) begin
          ac_ld_d  = 1'b1;
          ld_val_d = swreg;
          err_d    = 1'b0;
        end else if (deposit) begin
          addr_d  = cpu_pc;
          wdata_d = swreg;
          err_d   = 1'b0;
          state_d = S_DEP_WAIT;
        end else if (step) begin
          err_d   = 1'b0;
          state_d = S_STEP_WAIT;
        end
      end
      S_RUN: begin
        if (!run) state_d = instr_done ? S_IDLE : S_HALTING;
      end
      S_HALTING: begin
        if (run)             state_d = S_RUN;
        else if (instr_done) state_d = S_IDLE;
      end
      S_STEP_WAIT: begin
        if (step_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DEP_WAIT: begin
        // an ack on the last allowed cycle still completes the deposit
        if (mem_wr_ack) begin
          pc_ld_d  = 1'b1;
          ld_val_d = addr_q + DW'(1);
          state_d  = S_DEP_INC;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DEP_INC: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_run    = (state_q == S_RUN) || (state_q == S_HALTING);
    step_req   = (state_q == S_STEP_WAIT);
    mem_wr_req = (state_q == S_DEP_WAIT);
    fp_busy    = (state_q != S_IDLE);
    pc_ld      = pc_ld_q;
    ac_ld      = ac_ld_q;
    ld_val     = ld_val_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    fp_err     = err_q;
    dispout    = disp_q;
    linkout    = link_q;
  end

endmodule

// File: tb/tb_fp_console_ctrl.sv
// Scoreboarded bench for fp_console_ctrl: expected load strobes and memory writes are queued
// as commands are driven and retired by a monitor as the DUT produces them.
module tb_fp_console_ctrl;
  localparam int DW = 12;

  logic          clock = 1'b0;
  logic          reset, run, loadpc, loadac, step, deposit;
  logic [DW-1:0] swreg;
  logic [1:0]    dispsel;
  logic [DW-1:0] dispout;
  logic          linkout;
  logic [DW-1:0] cpu_pc, cpu_ac, cpu_mb, cpu_ir;
  logic          cpu_link, instr_done, cpu_run, step_req, step_done;
  logic          pc_ld, ac_ld;
  logic [DW-1:0] ld_val;
  logic          mem_wr_req;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_wr_ack, fp_busy, fp_err;

  fp_console_ctrl #(.DW(DW), .ACK_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .run(run), .loadpc(loadpc), .loadac(loadac),
    .step(step), .deposit(deposit), .swreg(swreg), .dispsel(dispsel),
    .dispout(dispout), .linkout(linkout), .cpu_pc(cpu_pc), .cpu_ac(cpu_ac),
    .cpu_mb(cpu_mb), .cpu_ir(cpu_ir), .cpu_link(cpu_link), .instr_done(instr_done),
    .cpu_run(cpu_run), .step_req(step_req), .step_done(step_done), .pc_ld(pc_ld),
    .ac_ld(ac_ld), .ld_val(ld_val), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack), .fp_busy(fp_busy), .fp_err(fp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            kind; // 0=pc_ld 1=ac_ld 2=memory write
    logic [DW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int kind, input logic [DW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.kind = kind; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  // Monitor retires scoreboard entries as strobes / write requests appear.
  logic          req_prev = 1'b0;
  logic [DW-1:0] req_addr, req_data;
  always @(posedge clock) begin
    exp_t e;
    #2;
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (pc_ld === 1'b1 || ac_ld === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_ld: got pc_ld=%b ac_ld=%b ld_val=%o, none expected", pc_ld, ac_ld, ld_val);
        end else begin
          e = sb.pop_front();
          if ((e.kind == 0 && (pc_ld !== 1'b1 || ac_ld !== 1'b0)) ||
              (e.kind == 1 && (ac_ld !== 1'b1 || pc_ld !== 1'b0)) ||
              e.kind == 2 || ld_val !== e.a) begin
            n_fail++;
            $display("FAIL sb_ld: got pc_ld=%b ac_ld=%b ld_val=%o, want kind=%0d ld_val=%o", pc_ld, ac_ld, ld_val, e.kind, e.a);
          end
        end
      end
      if (mem_wr_req === 1'b1 && !req_prev) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_wr: got addr=%o data=%o, none expected", mem_addr, mem_wdata);
        end else begin
          e = sb.pop_front();
          if (e.kind != 2 || mem_addr !== e.a || mem_wdata !== e.d) begin
            n_fail++;
            $display("FAIL sb_wr: got addr=%o data=%o, want kind=%0d addr=%o data=%o", mem_addr, mem_wdata, e.kind, e.a, e.d);
          end
        end
        req_addr = mem_addr;
        req_data = mem_wdata;
      end else if (mem_wr_req === 1'b1) begin
        n_chk++;
        if (mem_addr !== req_addr || mem_wdata !== req_data) begin
          n_fail++;
          $display("FAIL wr_stable: got addr=%o data=%o, want addr=%o data=%o", mem_addr, mem_wdata, req_addr, req_data);
        end
      end
      req_prev = (mem_wr_req === 1'b1);
    end
  end

  task automatic test_reset();
    logic [DW-1:0] exp;
    reset = 1'b1; run = 0; loadpc = 0; loadac = 0; step = 0; deposit = 0;
    swreg = '0; dispsel = 2'b01; cpu_pc = 12'o1111; cpu_ac = 12'o1234;
    cpu_mb = 12'o3333; cpu_ir = 12'o4444; cpu_link = 1'b1;
    instr_done = 0; step_done = 0; mem_wr_ack = 0;
    cyc(); cyc();
    n_chk++;
    if ({dispout, linkout, cpu_run, step_req, pc_ld, ac_ld, mem_wr_req, fp_busy, fp_err} !== '0 ||
        ld_val !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got disp=%o link=%b run=%b sreq=%b pld=%b ald=%b wreq=%b busy=%b err=%b, want all 0",
               dispout, linkout, cpu_run, step_req, pc_ld, ac_ld, mem_wr_req, fp_busy, fp_err);
    end
    reset = 1'b0;
    cyc();
    n_chk++;
    if (dispout !== 12'o1234 || linkout !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_disp_ac: got disp=%o link=%b, want 1234 1", dispout, linkout);
    end
    n_chk++;
    if ({cpu_run, step_req, pc_ld, ac_ld, mem_wr_req, fp_busy, fp_err} !== '0) begin
      n_fail++;
      $display("FAIL idle_ctrl: got %b, want 0000000", {cpu_run, step_req, pc_ld, ac_ld, mem_wr_req, fp_busy, fp_err});
    end
  endtask

  task automatic test_display();
    logic [DW-1:0] exp;
    for (int s = 0; s < 4; s++) begin
      dispsel = 2'(s);
      case (s)
        0: exp = 12'o1111;
        1: exp = 12'o1234;
        2: exp = 12'o3333;
        default: exp = 12'o4444;
      endcase
      cyc();
      n_chk++;
      if (dispout !== exp) begin
        n_fail++;
        $display("FAIL disp_sel%0d: got %o, want %o", s, dispout, exp);
      end
    end
    cpu_link = 1'b0;
    cyc();
    n_chk++;
    if (linkout !== 1'b0) begin
      n_fail++;
      $display("FAIL linkout: got %b, want 0", linkout);
    end
  endtask

  task automatic test_load();
    swreg = 12'o0200; loadpc = 1; push(0, 12'o0200, '0);
    cyc(); loadpc = 0;
    n_chk++;
    if (pc_ld !== 1'b1 || ac_ld !== 1'b0 || ld_val !== 12'o0200 || fp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL loadpc: got pc_ld=%b ac_ld=%b ld_val=%o busy=%b, want 1 0 0200 0", pc_ld, ac_ld, ld_val, fp_busy);
    end
    cyc();
    n_chk++;
    if (pc_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL loadpc_one_cycle: got pc_ld=%b, want 0", pc_ld);
    end
    swreg = 12'o6543; loadpc = 1; loadac = 1; push(0, 12'o6543, '0);
    cyc(); loadpc = 0; loadac = 0;
    n_chk++;
    if (pc_ld !== 1'b1 || ac_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL loadpc_prio: got pc_ld=%b ac_ld=%b, want 1 0", pc_ld, ac_ld);
    end
    swreg = 12'o0017; loadac = 1; deposit = 1; push(1, 12'o0017, '0);
    cyc(); loadac = 0; deposit = 0;
    n_chk++;
    if (ac_ld !== 1'b1 || mem_wr_req !== 1'b0 || fp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL loadac_prio: got ac_ld=%b wreq=%b busy=%b, want 1 0 0", ac_ld, mem_wr_req, fp_busy);
    end
    cyc();
  endtask

  task automatic test_deposit();
    cpu_pc = 12'o7777; swreg = 12'o5252; deposit = 1;
    push(2, 12'o7777, 12'o5252); push(0, 12'o0000, '0);
    cyc(); deposit = 0;
    cpu_pc = 12'o0100; swreg = 12'o0000; step = 1; // changed inputs and a pulse while busy
    n_chk++;
    if (mem_wr_req !== 1'b1 || fp_busy !== 1'b1 || mem_addr !== 12'o7777 || mem_wdata !== 12'o5252) begin
      n_fail++;
      $display("FAIL dep_req: got wreq=%b busy=%b addr=%o data=%o, want 1 1 7777 5252", mem_wr_req, fp_busy, mem_addr, mem_wdata);
    end
    cyc(); step = 0;
    cyc();
    mem_wr_ack = 1;
    cyc(); mem_wr_ack = 0;
    n_chk++;
    if (mem_wr_req !== 1'b0 || pc_ld !== 1'b1 || ld_val !== 12'o0000 || step_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dep_inc: got wreq=%b pc_ld=%b ld_val=%o sreq=%b, want 0 1 0000 0", mem_wr_req, pc_ld, ld_val, step_req);
    end
    cyc();
    n_chk++;
    if (pc_ld !== 1'b0 || fp_busy !== 1'b0 || fp_err !== 1'b0 || step_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dep_done: got pc_ld=%b busy=%b err=%b sreq=%b, want 0 0 0 0", pc_ld, fp_busy, fp_err, step_req);
    end
  endtask

  task automatic test_ack_last_cycle();
    cpu_pc = 12'o0040; swreg = 12'o1357; deposit = 1;
    push(2, 12'o0040, 12'o1357); push(0, 12'o0041, '0);
    cyc(); deposit = 0;
    for (int i = 0; i < 7; i++) cyc();
    n_chk++;
    if (mem_wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL dep_cycle8_req: got wreq=%b, want 1", mem_wr_req);
    end
    mem_wr_ack = 1;
    cyc(); mem_wr_ack = 0;
    n_chk++;
    if (pc_ld !== 1'b1 || ld_val !== 12'o0041 || fp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL dep_ack_last: got pc_ld=%b ld_val=%o err=%b, want 1 0041 0", pc_ld, ld_val, fp_err);
    end
    cyc();
  endtask

  task automatic test_step();
    int n;
    step = 1;
    cyc(); step = 0;
    n_chk++;
    if (step_req !== 1'b1 || fp_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL step_req: got sreq=%b busy=%b, want 1 1", step_req, fp_busy);
    end
    cyc(); cyc();
    step_done = 1;
    cyc(); step_done = 0;
    n_chk++;
    if (step_req !== 1'b0 || fp_busy !== 1'b0 || fp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL step_done: got sreq=%b busy=%b err=%b, want 0 0 0", step_req, fp_busy, fp_err);
    end
    // step_done never returns
    step = 1;
    cyc(); step = 0;
    n = 0;
    while (step_req === 1'b1 && n < 50) begin
      n++;
      cyc();
    end
    n_chk++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL step_timeout_len: got %0d cycles of step_req, want 8", n);
    end
    n_chk++;
    if (fp_err !== 1'b1 || fp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL step_timeout_err: got err=%b busy=%b, want 1 0", fp_err, fp_busy);
    end
    cyc();
    swreg = 12'o0077; loadac = 1; push(1, 12'o0077, '0);
    cyc(); loadac = 0;
    n_chk++;
    if (fp_err !== 1'b0 || ac_ld !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b ac_ld=%b, want 0 1", fp_err, ac_ld);
    end
    cyc();
  endtask

  task automatic test_run();
    run = 1;
    cyc();
    n_chk++;
    if (cpu_run !== 1'b1 || fp_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start: got cpu_run=%b busy=%b, want 1 1", cpu_run, fp_busy);
    end
    step = 1; loadpc = 1; swreg = 12'o2222;
    cyc(); step = 0; loadpc = 0;
    cyc();
    n_chk++;
    if (step_req !== 1'b0 || pc_ld !== 1'b0 || cpu_run !== 1'b1) begin
      n_fail++;
      $display("FAIL run_ignore: got sreq=%b pc_ld=%b cpu_run=%b, want 0 0 1", step_req, pc_ld, cpu_run);
    end
    run = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if (cpu_run !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold%0d: got cpu_run=%b, want 1", i, cpu_run);
      end
    end
    instr_done = 1;
    cyc(); instr_done = 0;
    n_chk++;
    if (cpu_run !== 1'b0 || fp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_done: got cpu_run=%b busy=%b, want 0 0", cpu_run, fp_busy);
    end
    // re-run during HALTING keeps cpu_run high; instr_done with the run fall stops at once
    run = 1; cyc();
    run = 0; cyc();
    run = 1; cyc();
    n_chk++;
    if (cpu_run !== 1'b1 || dut.state_q != 1) begin
      n_fail++;
      $display("FAIL rerun: got cpu_run=%b state=%0d, want 1 1", cpu_run, dut.state_q);
    end
    run = 0; instr_done = 1;
    cyc(); instr_done = 0;
    n_chk++;
    if (cpu_run !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_same_cycle: got cpu_run=%b, want 0", cpu_run);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    cpu_pc = 12'o0500; swreg = 12'o0123; deposit = 1;
    push(2, 12'o0500, 12'o0123);
    cyc(); deposit = 0;
    cyc();
    reset = 1;
    cyc();
    n_chk++;
    if (mem_wr_req !== 1'b0 || fp_busy !== 1'b0 || pc_ld !== 1'b0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got wreq=%b busy=%b pc_ld=%b addr=%o, want 0 0 0 0", mem_wr_req, fp_busy, pc_ld, mem_addr);
    end
    reset = 0;
    cyc(); cyc();
    n_chk++;
    if (mem_wr_req !== 1'b0 || fp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got wreq=%b busy=%b, want 0 0", mem_wr_req, fp_busy);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_load();
    test_deposit();
    test_ack_last_cycle();
    test_step();
    test_run();
    test_reset_mid();
    cyc();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
